// File: rtl/ysyx_22040088_if_id_queue_pkg.sv
// Shared IF/ID definitions: datapath widths, reset PC, NOP encoding and the queue entry layout.
package ysyx_22040088_defs;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;
  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            jump;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/ysyx_22040088_if_id_queue_if.sv
// Valid/ready instruction channel between fetch, the IF/ID queue and decode.
interface ysyx_22040088_if_id_queue_if;
  import ysyx_22040088_defs::*;

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [ILEN-1:0] inst;
  logic            jump;

  modport master (output valid, output pc, output inst, output jump, input ready);
  modport slave  (input valid, input pc, input inst, input jump, output ready);

endinterface

// File: rtl/ysyx_22040088_fifo_mem.sv
// DEPTH x W register file: one clocked write port, one asynchronous read port.
module ysyx_22040088_fifo_mem
  import ysyx_22040088_defs::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Payload storage needs no reset; the queue gates reads with its occupancy count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_22040088_if_id_queue.sv
// IF/ID instruction queue: circular buffer of fetched {pc, inst, jump} entries,
// drained in order by decode, emptied by a branch flush.
module ysyx_22040088_if_id_queue
  import ysyx_22040088_defs::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  ysyx_22040088_if_id_queue_if.slave    in_port,
  ysyx_22040088_if_id_queue_if.master   out_port
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  entry_t           wr_entry;
  entry_t           head;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign enq   = in_port.valid & ~full & ~flush;
  assign deq   = ~empty & out_port.ready & ~flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (!enq && deq) count <= count - CNT_W'(1);
    end
  end

  assign wr_entry = '{pc: in_port.pc, inst: in_port.inst, jump: in_port.jump};

  ysyx_22040088_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Ready and head depend only on registered state, so reset clears them without a clock edge.
  assign in_port.ready  = ~full;
  assign out_port.valid = ~empty;
  assign out_port.pc    = empty ? '0       : head.pc;
  assign out_port.inst  = empty ? INST_NOP : head.inst;
  assign out_port.jump  = empty ? 1'b0     : head.jump;

endmodule

// File: tb/tb_ysyx_22040088_if_id_queue.sv
// Bench for the IF/ID queue: directed vector table, reset corner and a random run against a queue model.
module tb_ysyx_22040088_if_id_queue;
  import ysyx_22040088_defs::*;

  localparam int unsigned DEPTH = 2;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  ysyx_22040088_if_id_queue_if in_bus ();
  ysyx_22040088_if_id_queue_if out_bus ();

  ysyx_22040088_if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_port  (in_bus),
    .out_port (out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            iv;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            jmp;
    logic            ordy;
    logic            fl;
    logic            e_ov;
    logic [XLEN-1:0] e_pc;
    logic [ILEN-1:0] e_inst;
    logic            e_jmp;
    logic            e_ir;
  } vec_t;

  vec_t   vecs [16];
  entry_t mq [$];

  function automatic vec_t mk(input logic iv, input logic [63:0] pc, input logic [31:0] inst,
                              input logic jmp, input logic ordy, input logic fl,
                              input logic e_ov, input logic [63:0] e_pc, input logic [31:0] e_inst,
                              input logic e_jmp, input logic e_ir);
    vec_t v;
    v.iv = iv; v.pc = pc; v.inst = inst; v.jmp = jmp; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst; v.e_jmp = e_jmp; v.e_ir = e_ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_ov, input logic [63:0] e_pc,
                               input logic [31:0] e_inst, input logic e_jmp, input logic e_ir);
    chk({tag, ".out_valid"}, 64'(out_bus.valid), 64'(e_ov));
    chk({tag, ".out_pc"},    out_bus.pc,         e_pc);
    chk({tag, ".out_inst"},  64'(out_bus.inst),  64'(e_inst));
    chk({tag, ".out_jump"},  64'(out_bus.jump),  64'(e_jmp));
    chk({tag, ".in_ready"},  64'(in_bus.ready),  64'(e_ir));
  endtask

  task automatic drive(input logic iv, input logic [63:0] pc, input logic [31:0] inst,
                       input logic jmp, input logic ordy, input logic fl);
    in_bus.valid  = iv;
    in_bus.pc     = pc;
    in_bus.inst   = inst;
    in_bus.jump   = jmp;
    out_bus.ready = ordy;
    flush         = fl;
  endtask

  // Inputs change at the falling edge; outputs are inspected at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: a bounded FIFO of entries; flush empties it, capacity is judged before the pop.
  task automatic model_step(input logic iv, input logic [63:0] pc, input logic [31:0] inst,
                            input logic jmp, input logic ordy, input logic fl);
    entry_t e;
    bit     can_in;
    bit     pop;
    e = '{pc: pc, inst: inst, jump: jmp};
    if (fl) begin
      mq.delete();
    end else begin
      can_in = (mq.size() < DEPTH);
      pop    = (mq.size() != 0) && ordy;
      if (pop) void'(mq.pop_front());
      if (iv && can_in) mq.push_back(e);
    end
  endtask

  task automatic check_model(input string tag);
    if (mq.size() != 0)
      check_outputs(tag, 1'b1, mq[0].pc, mq[0].inst, mq[0].jump, 1'(mq.size() < DEPTH));
    else
      check_outputs(tag, 1'b0, 64'h0, INST_NOP, 1'b0, 1'b1);
  endtask

  initial begin
    logic            r_iv, r_ordy, r_fl, r_jmp;
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_inst;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Streaming, fill, full with drain, flush, jump flag, empty with out_ready.
    vecs[0]  = mk(1'b1, RESET_PC,        32'h0010_0093, 1'b0, 1'b1, 1'b0, 1'b1, RESET_PC,        32'h0010_0093, 1'b0, 1'b1);
    vecs[1]  = mk(1'b1, 64'h8000_0004,   32'h0020_0113, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0004,   32'h0020_0113, 1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 64'h8000_0008,   32'h0030_0193, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0008,   32'h0030_0193, 1'b0, 1'b1);
    vecs[3]  = mk(1'b0, 64'h0,           32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 64'h0,           INST_NOP,      1'b0, 1'b1);
    vecs[4]  = mk(1'b1, RESET_PC,        32'h0010_0093, 1'b0, 1'b0, 1'b0, 1'b1, RESET_PC,        32'h0010_0093, 1'b0, 1'b1);
    vecs[5]  = mk(1'b1, 64'h8000_0004,   32'h0020_0113, 1'b0, 1'b0, 1'b0, 1'b1, RESET_PC,        32'h0010_0093, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 64'h8000_0008,   32'h0030_0193, 1'b0, 1'b0, 1'b0, 1'b1, RESET_PC,        32'h0010_0093, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 64'h8000_000C,   32'h0040_0213, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0004,   32'h0020_0113, 1'b0, 1'b1);
    vecs[8]  = mk(1'b0, 64'h0,           32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 64'h0,           INST_NOP,      1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 64'h8000_0010,   32'h0050_0293, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0010,   32'h0050_0293, 1'b0, 1'b1);
    vecs[10] = mk(1'b1, 64'h8000_0014,   32'h0060_0313, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0010,   32'h0050_0293, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 64'h8000_0018,   32'h0070_0393, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0,           INST_NOP,      1'b0, 1'b1);
    vecs[12] = mk(1'b0, 64'h0,           32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 64'h0,           INST_NOP,      1'b0, 1'b1);
    vecs[13] = mk(1'b1, 64'h8000_0020,   32'h0080_006F, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0020,   32'h0080_006F, 1'b1, 1'b1);
    vecs[14] = mk(1'b1, 64'h8000_0024,   32'h0000_0093, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0024,   32'h0000_0093, 1'b0, 1'b1);
    vecs[15] = mk(1'b0, 64'h0,           32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 64'h0,           INST_NOP,      1'b0, 1'b1);

    step();
    check_outputs("reset", 1'b0, 64'h0, INST_NOP, 1'b0, 1'b1);
    rst = 1'b0;
    step();
    check_outputs("post_reset_idle", 1'b0, 64'h0, INST_NOP, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].jmp, vecs[i].ordy, vecs[i].fl);
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_inst,
                    vecs[i].e_jmp, vecs[i].e_ir);
    end

    // Asynchronous reset with two entries held: outputs clear before any clock edge.
    drive(1'b1, 64'h8000_0100, 32'h0011_0113, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h8000_0104, 32'h0022_0213, 1'b0, 1'b0, 1'b0);
    step();
    check_outputs("full_before_rst", 1'b1, 64'h8000_0100, 32'h0011_0113, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 64'h0, INST_NOP, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 64'h8000_0200, 32'h0033_0313, 1'b0, 1'b0, 1'b0);
    step();
    check_outputs("after_rst_enq", 1'b1, 64'h8000_0200, 32'h0033_0313, 1'b0, 1'b1);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    check_outputs("after_rst_drain", 1'b0, 64'h0, INST_NOP, 1'b0, 1'b1);

    // Random traffic against the queue model.
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      r_iv   = ($urandom_range(0, 3) != 0);
      r_ordy = ($urandom_range(0, 2) != 0);
      r_fl   = ($urandom_range(0, 15) == 0);
      r_jmp  = ($urandom_range(0, 7) == 0);
      r_pc   = {$urandom, $urandom};
      r_inst = $urandom;
      drive(r_iv, r_pc, r_inst, r_jmp, r_ordy, r_fl);
      model_step(r_iv, r_pc, r_inst, r_jmp, r_ordy, r_fl);
      step();
      check_model($sformatf("rand%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
